hold_ctrl: RTL

Pipeline hold/flush scheduler for the tinyriscv core. It arbitrates stall and flush requests from ex (jumps, multi-cycle ops), the rib bus (foreign master) and clint (interrupt entry). It drives the shared `hold_flag_o` bus consumed by pc_reg, if_id and id_ex, and sequences post-jump flush cycles, the interrupt accept/drain handshake, a bus-stall watchdog and a stall-cycle performance counter.

---
 rtl/hold_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/hold_ctrl.sv
// Pipeline hold/flush scheduler: arbitrates ex, rib and clint stall/flush
// requests onto the shared hold bus, plus bus watchdog and stall counter.
module hold_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int RIB_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_ex_i,
    input  logic        hold_rib_i,
    input  logic        int_req_i,
    input  logic        int_done_i,
    input  logic [31:0] int_addr_i,
    input  logic        stall_clr_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        int_ack_o,
    output logic        rib_timeout_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        INT_ACTIVE
    } state_t;

    localparam logic [1:0]  FC = 2'(FLUSH_CYCLES);
    localparam logic [15:0] RT = 16'(RIB_TIMEOUT);
    localparam logic [15:0] RT_LAST = RT - 16'd1;

    state_t      state;
    logic [1:0]  fcnt;
    logic [15:0] rcnt;
    logic [31:0] stall_cnt;

    logic jump_req;
    logic int_jump;
    logic redirect;

    always_comb begin
        jump_req = jump_flag_i && (state != INT_ACTIVE);
        int_jump = int_done_i && (state == INT_ACTIVE);
        redirect = !rst && (jump_req || int_jump);

        jump_flag_o = redirect;
        jump_addr_o = 32'd0;
        if (!rst) begin
            unique case (1'b1)
                jump_req: jump_addr_o = jump_addr_i;
                int_jump: jump_addr_o = int_addr_i;
                default:  jump_addr_o = 32'd0;
            endcase
        end

        int_ack_o = !rst && (state == RUN) && !jump_flag_i &&
                    int_req_i && !hold_ex_i;

        // Highest active contribution wins; reset holds everything.
        if (rst || redirect || hold_ex_i || state == INT_ACTIVE)
            hold_flag_o = 3'd3;
        else if (state == FLUSH)
            hold_flag_o = 3'd2;
        else if (hold_rib_i)
            hold_flag_o = 3'd1;
        else
            hold_flag_o = 3'd0;

        rib_timeout_o = !rst && (RT != 16'd0) && hold_rib_i &&
                        (rcnt == RT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            fcnt  <= 2'd0;
        end else if (redirect) begin
            if (FC == 2'd0) begin
                state <= RUN;
                fcnt  <= 2'd0;
            end else begin
                state <= FLUSH;
                fcnt  <= FC;
            end
        end else begin
            case (state)
                RUN: begin
                    if (int_ack_o)
                        state <= INT_ACTIVE;
                end
                FLUSH: begin
                    if (fcnt <= 2'd1) begin
                        state <= RUN;
                        fcnt  <= 2'd0;
                    end else begin
                        fcnt <= fcnt - 2'd1;
                    end
                end
                INT_ACTIVE: state <= INT_ACTIVE;
                default: begin
                    state <= RUN;
                    fcnt  <= 2'd0;
                end
            endcase
        end
    end

    // Watchdog saturates so the timeout pulses once per hold episode.
    always_ff @(posedge clk) begin
        if (rst || !hold_rib_i)
            rcnt <= 16'd0;
        else if (rcnt != RT)
            rcnt <= rcnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || stall_clr_i)
            stall_cnt <= 32'd0;
        else if (hold_flag_o != 3'd0)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign stall_cnt_o = stall_cnt;

endmodule
